// File: rtl/debounce_edge_pkg.sv
// rtl/debounce_edge_pkg.sv - shared defaults for the debouncer
package debounce_edge_pkg;

    localparam int STABLE_CYCLES_DEF = 4;
    localparam int CNT_W_DEF         = 16;

endpackage

// File: rtl/debounce_edge_sync2.sv
// rtl/debounce_edge_sync2.sv - two-flop synchronizer for the raw debounce input
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - debounced level with one-cycle rise/fall pulses
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             d_s;
    logic [CNT_W-1:0] cnt;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (d_s)
    );

    // Count only while the synchronized input disagrees with q; the final
    // count commits the change, so cnt never exceeds LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
            cnt  <= '0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (d_s == q) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                q    <= d_s;
                cnt  <= '0;
                rise <= d_s;
                fall <= ~d_s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign busy = d_s ^ q;

endmodule
